// File: rtl/word_serializer.sv
// Handshaked word-to-lane serializer: captures one WORD_W word and streams its
// LANE_W lanes MSB- or LSB-first, with a partial length and no bubble between words.
module word_serializer #(
    parameter  int WORD_W = 32,
    parameter  int LANE_W = 8,
    localparam int NLANES = WORD_W / LANE_W,
    localparam int CNT_W  = $clog2(NLANES) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_msb_first,
    input  logic [CNT_W-1:0]  in_len,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LANE_W-1:0] out_data,
    output logic [CNT_W-2:0]  out_idx,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [CNT_W-1:0] NLANES_C = CNT_W'(NLANES);
    localparam logic [CNT_W-2:0] TOP_IDX  = (CNT_W-1)'(NLANES - 1);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q;
    logic                msb_q;
    logic [CNT_W-1:0]    len_q;
    logic [CNT_W-2:0]    idx_q;

    logic [CNT_W-1:0]    len_clamped;
    logic [CNT_W-2:0]    sel;
    logic [LANE_W-1:0]   lanes [NLANES];
    logic                last, xfer, accept;

    always_comb begin
        len_clamped = in_len;
        if (in_len == '0 || in_len > NLANES_C)
            len_clamped = NLANES_C;
    end

    always_comb begin
        for (int unsigned i = 0; i < NLANES; i++)
            lanes[i] = word_q[i*LANE_W +: LANE_W];
    end

    // in_ready depends combinationally on out_ready (reload on the last beat);
    // integrators must account for that path.
    always_comb begin
        busy      = (state_q == SEND);
        out_valid = busy;
        last      = busy && ({1'b0, idx_q} == len_q - 1'b1);
        out_last  = last;
        sel       = msb_q ? TOP_IDX - idx_q : idx_q;
        out_data  = busy ? lanes[sel] : '0;
        out_idx   = busy ? idx_q : '0;
        xfer      = out_valid && out_ready;
        in_ready  = !reset && (state_q == IDLE || (xfer && last));
        accept    = in_valid && in_ready;

        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (xfer && last && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            len_q   <= NLANES_C;
            msb_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                word_q <= in_data;
                msb_q  <= in_msb_first;
                len_q  <= len_clamped;
                idx_q  <= '0;
            end else if (xfer && !last) begin
                idx_q  <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: lane-queue reference model checked every
// cycle, plus literal expectations on the emitted lane sequences.
module tb_word_serializer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] in_data;
    logic        in_msb_first;
    logic [2:0]  in_len;
    logic        in_valid, in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_last, out_valid, out_ready, busy;

    logic [63:0] in_data64;
    logic        in_valid64, in_ready64;
    logic [15:0] out_data64;
    logic [1:0]  out_idx64;
    logic        out_last64, out_valid64, out_ready64, busy64;

    word_serializer u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_msb_first(in_msb_first),
        .in_len(in_len), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    word_serializer #(.WORD_W(64), .LANE_W(16)) u_dut64 (
        .clk(clk), .reset(reset), .in_data(in_data64), .in_msb_first(1'b1),
        .in_len(3'd0), .in_valid(in_valid64), .in_ready(in_ready64), .out_data(out_data64),
        .out_idx(out_idx64), .out_last(out_last64), .out_valid(out_valid64),
        .out_ready(out_ready64), .busy(busy64)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Reference model: the lanes still owed to the consumer, in emission order.
    typedef struct {
        logic [7:0]  data;
        int unsigned idx;
        bit          last;
    } lane_t;

    lane_t      q[$];
    logic [7:0] got[$];
    bit         armed = 0;
    bit         exp_ready, ready_now;

    function automatic void push_word(input logic [31:0] w, input bit msb, input int unsigned len);
        int unsigned n;
        int unsigned pos;
        lane_t l;
        n = (len == 0 || len > 4) ? 4 : len;
        for (int unsigned k = 0; k < n; k++) begin
            pos    = msb ? 3 - k : k;
            l.data = 8'((w >> (pos * 8)) & 32'hFF);
            l.idx  = k;
            l.last = (k == n - 1);
            q.push_back(l);
        end
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            exp_ready = !reset && (q.size() == 0 || (out_ready && q[0].last));
            check("in_ready", in_ready, exp_ready);
            check("out_valid", out_valid, q.size() != 0);
            check("busy", busy, q.size() != 0);
            if (q.size() != 0) begin
                check("out_data", out_data, q[0].data);
                check("out_idx", out_idx, q[0].idx);
                check("out_last", out_last, q[0].last);
                if (out_ready && !reset) got.push_back(out_data);
            end else begin
                check("idle_out_data", out_data, 0);
                check("idle_out_idx", out_idx, 0);
                check("idle_out_last", out_last, 0);
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            armed = 1;
        end else if (armed) begin
            ready_now = (q.size() == 0 || (out_ready && q[0].last));
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && ready_now) push_word(in_data, in_msb_first, in_len);
        end
    end

    task automatic offer(input logic [31:0] w, input bit msb, input logic [2:0] len);
        in_data      = w;
        in_msb_first = msb;
        in_len       = len;
        in_valid     = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("offer_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!out_valid) break;
        end
        check("drain_valid", out_valid, 0);
        check("drain_busy", busy, 0);
        @(posedge clk); #1;
    endtask

    // First emitted lane sits in the most significant byte of the n-lane literal.
    task automatic expect_got(input string name, input logic [63:0] lit, input int unsigned n);
        logic [63:0] e;
        check({name, "_count"}, got.size(), n);
        for (int unsigned k = 0; k < n; k++) begin
            e = (lit >> ((n - 1 - k) * 8)) & 64'hFF;
            if (k < got.size()) check({name, "_lane"}, got[k], e);
        end
        got.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [6:0]  pat;
        logic [63:0] w64;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0;
        in_len = '0; out_ready = 1'b1;
        in_valid64 = 1'b0; in_data64 = '0; out_ready64 = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Basic MSB-first, full length
        offer(32'h12345678, 1'b1, 3'd0);
        @(negedge clk);
        check("t1_first_valid", out_valid, 1);
        check("t1_first_lane", out_data, 8'h12);
        drain();
        expect_got("t1", 64'h12345678, 4);

        // LSB-first partial, then over-range length clamps to full word
        offer(32'hA1B2C3D4, 1'b0, 3'd2);
        drain();
        expect_got("t2", 64'hD4C3, 2);
        offer(32'hA1B2C3D4, 1'b0, 3'd7);
        drain();
        expect_got("t2b", 64'hD4C3B2A1, 4);

        // Backpressure pattern 1,0,0,1,0,1,1 (first element applied first)
        pat = 7'b1001011;
        offer(32'hDEADBEEF, 1'b1, 3'd0);
        for (int i = 6; i >= 0; i--) begin
            out_ready = pat[i];
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();
        expect_got("t3", 64'hDEADBEEF, 4);

        // Back-to-back words with no bubble
        offer(32'h01020304, 1'b1, 3'd0);
        offer(32'h05060708, 1'b1, 3'd0);
        drain();
        expect_got("t4", 64'h0102030405060708, 8);

        // Reset after two lanes discards the rest of the word
        offer(32'hCAFEF00D, 1'b1, 3'd0);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_data", out_data, 0);
        @(posedge clk); #1;
        expect_got("t5", 64'hCAFE, 2);
        offer(32'h11223344, 1'b1, 3'd0);
        drain();
        expect_got("t5b", 64'h11223344, 4);

        // 64-bit word, 16-bit lanes, MSB-first
        w64 = 64'h0001_0002_0003_0004;
        in_data64  = w64;
        in_valid64 = 1'b1;
        @(negedge clk);
        check("w64_in_ready", in_ready64, 1);
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("w64_valid", out_valid64, 1);
            check("w64_data", out_data64, (w64 >> ((3 - k) * 16)) & 64'hFFFF);
            check("w64_idx", out_idx64, k);
            check("w64_last", out_last64, k == 3);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("w64_done_valid", out_valid64, 0);
        check("w64_done_busy", busy64, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
Parametrised, handshaked successor to the combinational word-to-byte splitter. It accepts one WORD_W-bit word and emits its LANE_W-bit lanes one per cycle on a valid/ready stream. It supports selectable lane order, partial-word length and back-to-back words without bubbles. It sits between a word-wide producer (register file or bus read port) and a narrow consumer (byte-wide UART/display/memory port).

Parameters:
WORD_W, 32, input word width in bits; must be an integer multiple of LANE_W.
LANE_W, 8, output lane width in bits.
NLANES, WORD_W/LANE_W (derived, localparam), lanes per word; must be >= 2.
CNT_W, clog2(NLANES)+1 (derived, localparam), width of length/index fields.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
in_data  input  WORD_W  word to serialize.
in_msb_first  input  1  1: lanes in order [WORD_W-1 -: LANE_W] first (O1-first order); 0: bits [LANE_W-1:0] first.
in_len  input  CNT_W  number of lanes to emit, 1..NLANES; 0 or >NLANES is treated as NLANES.
in_valid  input  1  producer offers word.
in_ready  output  1  block accepts word this cycle.
out_data  output  LANE_W  current lane.
out_idx  output  CNT_W-1  position of current lane within the burst (0 = first emitted).
out_last  output  1  current lane is the final lane of the word.
out_valid  output  1  out_data is valid.
out_ready  input  1  consumer takes lane.
busy  output  1  a word is held (state SEND).

Behaviour:
- Accept = in_valid && in_ready. Lane transfer = out_valid && out_ready.
- States: IDLE, SEND. Registers: word_q, msb_q, len_q (clamped), idx_q.
- IDLE: in_ready=1, out_valid=0. On accept: capture in_data/in_msb_first/clamped in_len, idx_q<=0, go to SEND. The first lane is valid the next cycle (latency 1).
- SEND: out_valid=1. out_data = lane idx_q, counted from the MSB end if msb_q=1, else from the LSB end. out_last=(idx_q==len_q-1). out_idx=idx_q.
- SEND, transfer with !out_last: idx_q<=idx_q+1.
- SEND, transfer with out_last: if in_valid, capture the new word and stay in SEND with idx_q<=0 (no bubble); else go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is a combinational path from out_ready; it is permitted and must be documented at integration.
- out_ready low: out_data/out_idx/out_last/out_valid hold stable; the word is never dropped or advanced.
- out_valid, once high, must not fall until a transfer occurs.
- in_data changes while not accepted: ignored. The captured word is immune to later in_data changes.
- len_q=1: single lane with out_last=1 on the first beat.
- Reset (synchronous, any state including mid-burst): state<=IDLE, idx_q<=0, word_q<=0, len_q<=NLANES, msb_q<=1.
  - After reset: out_valid=0, out_last=0, out_idx=0, out_data=0, busy=0.
  - in_ready=0 during any cycle where reset is high; 1 from the first cycle after reset.
  - A partially sent word is discarded.
- out_data in IDLE is driven 0 (not stale data).
- busy = (state==SEND).
- No combinational path from in_data to out_data.

Test Plan:
- Basic MSB-first: reset 2 cycles; in_data=32'h12345678, msb=1, len=0, in_valid 1 cycle, out_ready=1 -> first lane 1 cycle after accept; out_data 12,34,56,78 on 4 consecutive cycles; out_idx 0..3; out_last only with 78; then out_valid=0, busy=0.
- LSB-first and partial length: in_data=32'hA1B2C3D4, msb=0, len=2 -> out_data D4,C3, out_last on C3. Then len=7 (clamped) -> D4,C3,B2,A1.
- Backpressure: 32'hDEADBEEF msb=1; out_ready pattern 1,0,0,1,0,1,1 -> lanes DE,AD,BE,EF each held stable while out_ready=0; 4 transfers total; in_ready=0 throughout the burst except the EF transfer cycle.
- Back-to-back: words 32'h01020304 then 32'h05060708, in_valid held high, out_ready=1 -> 8 consecutive valid lanes 01..08 with no gap; in_ready high exactly on the 04 transfer cycle; out_last on 04 and 08.
- Reset mid-burst: start 32'hCAFEF00D; assert reset after 2 lanes (CA,FE) -> next cycle out_valid=0, busy=0, out_data=0. A subsequent word 32'h11223344 emits 11,22,33,44 from idx 0.
- Parametrisation: WORD_W=64, LANE_W=16, in_data=64'h0001_0002_0003_0004, msb=1 -> lanes 0001,0002,0003,0004, out_last on 0004.
